// File: rtl/calc_key_seq.sv
// Keypad sequencer for a small calculator: builds two decimal operands from
// debounced button levels, hands them to a datapath and shows the result.
module calc_key_seq #(
  parameter int MAX_DIGITS = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] keys,
  input  logic [2:0] func,
  input  logic       get_res,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  output logic       alu_start,
  input  logic       alu_done,
  input  logic [3:0] alu_res,
  output logic [3:0] res,
  output logic       res_valid,
  output logic       err,
  output logic       busy
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DIGITS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {ENTER_A, ENTER_B, ISSUE, WAIT, SHOW} state_t;

  state_t           state, state_nxt;
  logic [9:0]       keys_q;
  logic [2:0]       func_q;
  logic             get_q;
  logic             armed;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_cur;
  logic [TMO_W-1:0] tmo;
  logic [9:0]       key_rise;
  logic [3:0]       dig, acc_cur;
  logic [7:0]       acc_next;
  logic             dig_press, func_press, get_press;

  // armed stays low for the first cycle after reset so levels held across
  // reset release are absorbed into the edge registers without a press
  assign key_rise   = keys & ~keys_q & {10{armed}};
  assign dig_press  = (key_rise != '0) && ((key_rise & (key_rise - 10'd1)) == '0)
                      && ((keys & ~key_rise) == '0);
  assign func_press = armed && (func != '0) && (func_q == '0);
  assign get_press  = armed && get_res && !get_q;

  always_comb begin
    dig = '0;
    for (int i = 0; i < 10; i++)
      if (key_rise[i]) dig = 4'(i);
  end

  assign acc_cur  = (state == ENTER_B) ? alu_b : alu_a;
  assign cnt_cur  = (state == ENTER_B) ? cnt_b : cnt_a;
  assign acc_next = {4'd0, acc_cur} * 8'd10 + {4'd0, dig};

  always_ff @(posedge clk) begin
    if (reset) state <= ENTER_A;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ENTER_A: if (!dig_press && func_press && cnt_a != '0) state_nxt = ENTER_B;
      ENTER_B: if (!dig_press && !func_press && get_press && cnt_b != '0) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (alu_done) state_nxt = SHOW;
               else if (tmo == TMO_LAST) state_nxt = ENTER_A;
      SHOW:    if (dig_press) state_nxt = ENTER_A;
               else if (func_press) state_nxt = ENTER_B;
      default: state_nxt = ENTER_A;
    endcase
  end

  always_comb begin
    alu_start = (state == ISSUE);
    busy      = (state == ISSUE) || (state == WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keys_q <= '0; func_q <= '0; get_q <= 1'b0; armed <= 1'b0;
      alu_a <= '0; alu_b <= '0; cnt_a <= '0; cnt_b <= '0; alu_op <= '0;
      res <= '0; res_valid <= 1'b0; err <= 1'b0; tmo <= '0;
    end else begin
      keys_q <= keys;
      func_q <= func;
      get_q  <= get_res;
      armed  <= 1'b1;
      case (state)
        ENTER_A, ENTER_B: begin
          // a range-rejected digit still uses up a digit slot, so further
          // digits for that operand are then refused by count
          if (dig_press) begin
            if (cnt_cur < MAX_CNT) begin
              if (acc_next <= 8'd15) begin
                err <= 1'b0;
                if (state == ENTER_B) alu_b <= acc_next[3:0];
                else                  alu_a <= acc_next[3:0];
              end else begin
                err <= 1'b1;
              end
              if (state == ENTER_B) cnt_b <= cnt_b + 1'b1;
              else                  cnt_a <= cnt_a + 1'b1;
            end
          end else if (func_press) begin
            if (state == ENTER_B) begin
              alu_op <= func;
              alu_b  <= '0;
              cnt_b  <= '0;
            end else if (cnt_a != '0) begin
              alu_op <= func;
            end
          end
        end
        ISSUE: tmo <= '0;
        WAIT: begin
          if (alu_done) begin
            res       <= alu_res;
            res_valid <= 1'b1;
          end else if (tmo == TMO_LAST) begin
            err       <= 1'b1;
            res_valid <= 1'b0;
            alu_a <= '0; alu_b <= '0; cnt_a <= '0; cnt_b <= '0;
            tmo   <= '0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        SHOW: begin
          if (dig_press) begin
            alu_a <= dig; cnt_a <= CNT_W'(1);
            alu_b <= '0;  cnt_b <= '0;
            err <= 1'b0;  res_valid <= 1'b0;
          end else if (func_press) begin
            alu_a  <= res; cnt_a <= CNT_W'(1);
            alu_b  <= '0;  cnt_b <= '0;
            alu_op <= func;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_key_seq.sv
// Directed bench for calc_key_seq: operand entry, datapath handshake,
// timeout, reset abort and result chaining.
module tb_calc_key_seq;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] keys;
  logic [2:0] func;
  logic       get_res;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic       alu_start;
  logic       alu_done;
  logic [3:0] alu_res;
  logic [3:0] res;
  logic       res_valid, err, busy;

  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;

  calc_key_seq #(.MAX_DIGITS(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .keys(keys), .func(func), .get_res(get_res),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_res(alu_res), .res(res), .res_valid(res_valid),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (alu_start === 1'b1) start_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic press_key(input int d);
    keys = 10'(1 << d);
    tick();
    keys = '0;
    tick();
  endtask

  task automatic press_func(input logic [2:0] f);
    func = f;
    tick();
    func = '0;
    tick();
  endtask

  // leaves the bench one cycle after the press edge, i.e. in ISSUE if accepted
  task automatic press_get();
    get_res = 1'b1;
    tick();
    get_res = 1'b0;
  endtask

  initial begin
    reset = 1'b1; keys = '0; func = '0; get_res = 1'b0;
    alu_done = 1'b0; alu_res = '0;
    do_reset();
    chk("rst_alu_a", 8'(alu_a), 8'd0);
    chk("rst_alu_b", 8'(alu_b), 8'd0);
    chk("rst_alu_op", 8'(alu_op), 8'd0);
    chk("rst_res", 8'(res), 8'd0);
    chk("rst_flags", {4'd0, res_valid, err, busy, alu_start}, 8'd0);

    // 13 op1 01 = 14 with done two cycles after start
    start_cnt = 0;
    press_key(1);
    press_key(3);
    chk("a_13", 8'(alu_a), 8'd13);
    press_func(3'b001);
    press_key(0);
    press_key(1);
    chk("b_01", 8'(alu_b), 8'd1);
    chk("op_001", 8'(alu_op), 8'd1);
    press_get();
    chk("issue_start", 8'(alu_start), 8'd1);
    chk("issue_busy", 8'(busy), 8'd1);
    tick();
    chk("wait_nostart", 8'(alu_start), 8'd0);
    tick();
    alu_done = 1'b1; alu_res = 4'd14;
    tick();
    alu_done = 1'b0; alu_res = '0;
    chk("show_res", 8'(res), 8'd14);
    chk("show_valid", 8'(res_valid), 8'd1);
    chk("show_busy", 8'(busy), 8'd0);
    chk("start_once", 8'(start_cnt), 8'd1);
    chk("show_a_kept", 8'(alu_a), 8'd13);
    press_get();
    chk("show_get_ignored", 8'(busy), 8'd0);

    // chain from result 14: op 011, B = 2
    press_func(3'b011);
    chk("chain_a", 8'(alu_a), 8'd14);
    chk("chain_op", 8'(alu_op), 8'd3);
    press_key(2);
    press_get();
    chk("chain_issue_ab", {alu_a, alu_b}, {4'd14, 4'd2});
    chk("chain_issue_op", 8'(alu_op), 8'd3);
    tick();
    alu_done = 1'b1; alu_res = 4'd7;
    tick();
    alu_done = 1'b0;
    chk("chain_res", 8'(res), 8'd7);
    press_key(4);
    chk("show_digit_a", 8'(alu_a), 8'd4);
    chk("show_digit_b", 8'(alu_b), 8'd0);
    chk("show_digit_valid", 8'(res_valid), 8'd0);
    chk("show_digit_res", 8'(res), 8'd7);

    // range and count rejection
    do_reset();
    press_key(1);
    press_key(7);
    chk("range_a", 8'(alu_a), 8'd1);
    chk("range_err", 8'(err), 8'd1);
    press_key(2);
    chk("count_a", 8'(alu_a), 8'd1);
    chk("count_err", 8'(err), 8'd1);

    // two digits rising together, then a digit while another is held
    do_reset();
    keys = 10'b0000001010;
    tick();
    keys = '0;
    tick();
    chk("multi_a", 8'(alu_a), 8'd0);
    chk("multi_err", 8'(err), 8'd0);
    keys = 10'b0000000010;
    tick();
    chk("held_first", 8'(alu_a), 8'd1);
    keys = 10'b0000000110;
    tick();
    keys = '0;
    tick();
    chk("held_second_ignored", 8'(alu_a), 8'd1);

    // func with no A digits ignored, timeout path
    do_reset();
    press_func(3'b010);
    press_key(5);
    chk("func_nodigit_op", 8'(alu_op), 8'd0);
    press_func(3'b010);
    press_get();
    chk("get_noB_ignored", 8'(busy), 8'd0);
    press_key(3);
    press_get();
    chk("to_issue", 8'(alu_start), 8'd1);
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("to_last_wait_busy", {6'd0, busy, err}, 8'b10);
    tick();
    chk("to_err", 8'(err), 8'd1);
    chk("to_busy", 8'(busy), 8'd0);
    chk("to_valid", 8'(res_valid), 8'd0);
    chk("to_ab_clear", {alu_a, alu_b}, 8'd0);
    alu_done = 1'b1; alu_res = 4'd9;
    tick();
    alu_done = 1'b0;
    chk("done_outside_wait", {3'd0, res_valid, res}, 8'd0);
    press_key(6);
    chk("to_enter_a", 8'(alu_a), 8'd6);
    chk("to_err_cleared", 8'(err), 8'd0);

    // reset during WAIT aborts
    do_reset();
    press_key(2);
    press_func(3'b001);
    press_key(3);
    press_get();
    tick();
    chk("abort_in_wait", 8'(busy), 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    alu_done = 1'b1; alu_res = 4'd5;
    tick();
    alu_done = 1'b0;
    chk("abort_res", {3'd0, res_valid, res}, 8'd0);
    chk("abort_busy", 8'(busy), 8'd0);
    press_key(8);
    chk("abort_enter_a", 8'(alu_a), 8'd8);

    // key held across reset release
    reset = 1'b1;
    keys = 10'b0010000000;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("held_reset_a", 8'(alu_a), 8'd0);
    keys = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
